// File: rtl/led_pwm_pkg.sv
// Shared definitions for the LED PWM sequencer.
//   mode_e       : per-channel output mode encodings
//   REG_*        : register-map addresses (channel i: MODE at REG_CH_BASE+2i,
//                  DUTY at REG_CH_BASE+2i+1)
//   CTRL_*_BIT   : bit positions inside the CTRL register
package led_pwm_pkg;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_STATIC  = 2'd1,
    MODE_BLINK   = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_e;

  localparam int REG_CTRL    = 0;
  localparam int REG_PRESC   = 1;
  localparam int REG_CH_BASE = 2;

  localparam int CTRL_EN_BIT  = 0;
  localparam int CTRL_CLR_BIT = 1;

endpackage

// File: rtl/led_pwm_channel.sv
// One PWM channel: shadow/live MODE and DUTY registers, effective-duty
// selection (off/static/blink/breathe), optional square-law gamma stage and
// the registered output comparator.
// Optional feature macro: LED_PWM_GAMMA_EN (adds gamma stage, +1 latency).
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   mode_we, duty_we    shadow write strobes (decoded by the top)
//   mode_data, duty_data  shadow write data
//   load                copy shadow -> live (frame wrap or clear)
//   clear               force the output low for this cycle
//   enable              global output enable
//   pwm_cnt, phase      shared PWM counter and frame-phase counter
//   pwm                 registered PWM output
module led_pwm_channel
  import led_pwm_pkg::*;
#(
  parameter int PWM_W   = 8,
  parameter int PHASE_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mode_we,
  input  logic               duty_we,
  input  logic [1:0]         mode_data,
  input  logic [PWM_W-1:0]   duty_data,
  input  logic               load,
  input  logic               clear,
  input  logic               enable,
  input  logic [PWM_W-1:0]   pwm_cnt,
  input  logic [PHASE_W-1:0] phase,
  output logic               pwm
);

  mode_e                    mode_shadow_reg, mode_live_reg;
  logic [PWM_W-1:0]         duty_shadow_reg, duty_live_reg;
  logic [PHASE_W-2:0]       tri_val;
  logic [PWM_W+PHASE_W-2:0] breathe_prod;
  logic [PWM_W-1:0]         eff;
  logic [PWM_W-1:0]         level;
  logic [PWM_W-1:0]         cmp_cnt;
  logic                     pwm_reg;

  // A shadow write on a load cycle keeps the new value in the shadow; the
  // live copy takes the value the shadow held before the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_shadow_reg <= MODE_OFF;
      mode_live_reg   <= MODE_OFF;
      duty_shadow_reg <= '0;
      duty_live_reg   <= '0;
    end else begin
      if (load) begin
        mode_live_reg <= mode_shadow_reg;
        duty_live_reg <= duty_shadow_reg;
      end
      if (mode_we) mode_shadow_reg <= mode_e'(mode_data);
      if (duty_we) duty_shadow_reg <= duty_data;
    end
  end

  // Triangle wave over the phase: rises in the first half, falls in the second.
  assign tri_val      = phase[PHASE_W-1] ? ~phase[PHASE_W-2:0] : phase[PHASE_W-2:0];
  assign breathe_prod = {{(PHASE_W-1){1'b0}}, duty_live_reg} * {{PWM_W{1'b0}}, tri_val};

  always_comb begin
    eff = '0;
    case (mode_live_reg)
      MODE_OFF:     eff = '0;
      MODE_STATIC:  eff = duty_live_reg;
      MODE_BLINK:   eff = phase[PHASE_W-1] ? '0 : duty_live_reg;
      MODE_BREATHE: eff = breathe_prod[PWM_W+PHASE_W-2:PHASE_W-1];
      default:      eff = '0;
    endcase
  end

`ifdef LED_PWM_GAMMA_EN
  // Gamma stage registers both the level and the counter so the comparator
  // still sees a matched pair one cycle later.
  logic [2*PWM_W-1:0] gamma_sq;
  logic [PWM_W-1:0]   gamma_reg;
  logic [PWM_W-1:0]   cnt_dly_reg;

  assign gamma_sq = {{PWM_W{1'b0}}, eff} * {{PWM_W{1'b0}}, eff};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gamma_reg   <= '0;
      cnt_dly_reg <= '0;
    end else begin
      gamma_reg   <= gamma_sq[2*PWM_W-1:PWM_W];
      cnt_dly_reg <= pwm_cnt;
    end
  end

  assign level   = gamma_reg;
  assign cmp_cnt = cnt_dly_reg;
`else
  assign level   = eff;
  assign cmp_cnt = pwm_cnt;
`endif

  // Strict less-than: level 0 never drives high, full scale is high all but one count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_reg <= 1'b0;
    end else begin
      pwm_reg <= clear ? 1'b0 : (enable & (cmp_cnt < level));
    end
  end

  assign pwm = pwm_reg;

endmodule

// File: rtl/led_pwm_sequencer.sv
// Multi-channel LED PWM sequencer. Holds the shared prescaler, PWM counter,
// frame-phase counter and register decode; NUM_CH led_pwm_channel instances
// produce the outputs so all channels stay phase-coherent.
// Optional feature macro: LED_PWM_GAMMA_EN (gamma stage in each channel;
// frame_o is delayed one cycle to stay aligned with pwm_o).
// Ports:
//   clk      system clock
//   rst      asynchronous active-high reset
//   wr_en    register write strobe
//   wr_addr  register address
//   wr_data  register write data
//   pwm_o    per-channel registered PWM outputs
//   frame_o  one-cycle pulse at PWM counter wrap
//   phase_o  current frame-phase count
module led_pwm_sequencer
  import led_pwm_pkg::*;
#(
  parameter int                 NUM_CH    = 3,
  parameter int                 PWM_W     = 8,
  parameter int                 PHASE_W   = 8,
  parameter int                 PRESC_W   = 16,
  parameter logic [PRESC_W-1:0] PRESC_RST = PRESC_W'(46),
  parameter int                 ADDR_W    = 4,
  parameter int                 DATA_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0]  wr_data,
  output logic [NUM_CH-1:0]  pwm_o,
  output logic               frame_o,
  output logic [PHASE_W-1:0] phase_o
);

  logic               enable_reg;
  logic [PRESC_W-1:0] presc_reg;
  logic [PRESC_W-1:0] presc_cnt_reg;
  logic [PWM_W-1:0]   pwm_cnt_reg;
  logic [PHASE_W-1:0] phase_reg;
  logic               ctrl_we, presc_we, clear;
  logic               tick, frame_tick;
  logic               unused_wr_data;

  assign unused_wr_data = ^wr_data;

  assign ctrl_we  = wr_en && (wr_addr == ADDR_W'(REG_CTRL));
  assign presc_we = wr_en && (wr_addr == ADDR_W'(REG_PRESC));
  // Clear acts on the write edge itself; nothing is stored, so it self-clears.
  assign clear    = ctrl_we && wr_data[CTRL_CLR_BIT];

  assign tick       = (presc_cnt_reg == presc_reg);
  assign frame_tick = tick && (pwm_cnt_reg == '1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enable_reg    <= 1'b0;
      presc_reg     <= PRESC_RST;
      presc_cnt_reg <= '0;
      pwm_cnt_reg   <= '0;
      phase_reg     <= '0;
    end else begin
      if (ctrl_we)  enable_reg <= wr_data[CTRL_EN_BIT];
      if (presc_we) presc_reg  <= wr_data[PRESC_W-1:0];
      if (clear) begin
        presc_cnt_reg <= '0;
        pwm_cnt_reg   <= '0;
        phase_reg     <= '0;
      end else begin
        // >= also catches a count left above a freshly lowered reload value.
        presc_cnt_reg <= (presc_cnt_reg >= presc_reg) ? '0 : presc_cnt_reg + PRESC_W'(1);
        if (tick)       pwm_cnt_reg <= pwm_cnt_reg + PWM_W'(1);
        if (frame_tick) phase_reg   <= phase_reg + PHASE_W'(1);
      end
    end
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic mode_we, duty_we;
    assign mode_we = wr_en && (wr_addr == ADDR_W'(REG_CH_BASE + 2*gi));
    assign duty_we = wr_en && (wr_addr == ADDR_W'(REG_CH_BASE + 2*gi + 1));

    led_pwm_channel #(
      .PWM_W   (PWM_W),
      .PHASE_W (PHASE_W)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .mode_we   (mode_we),
      .duty_we   (duty_we),
      .mode_data (wr_data[1:0]),
      .duty_data (wr_data[PWM_W-1:0]),
      .load      (frame_tick | clear),
      .clear     (clear),
      .enable    (enable_reg),
      .pwm_cnt   (pwm_cnt_reg),
      .phase     (phase_reg),
      .pwm       (pwm_o[gi])
    );
  end

`ifdef LED_PWM_GAMMA_EN
  logic frame_dly_reg;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) frame_dly_reg <= 1'b0;
    else     frame_dly_reg <= frame_tick;
  end
  assign frame_o = frame_dly_reg;
`else
  assign frame_o = frame_tick;
`endif

  assign phase_o = phase_reg;

endmodule

// File: tb/tb_led_pwm_sequencer.sv
// Self-checking bench for led_pwm_sequencer: a behavioural model (tick
// counting, arithmetic duty rules) is stepped every clock and compared with
// the DUT, plus directed duty-count / period checks from the test plan and a
// randomized register-write phase.
module tb_led_pwm_sequencer;

  localparam int NUM_CH = 3;
`ifdef LED_PWM_GAMMA_EN
  localparam int LAT_EXTRA = 1;
`else
  localparam int LAT_EXTRA = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic [2:0]  pwm_o;
  logic        frame_o;
  logic [7:0]  phase_o;

  always #5 clk = ~clk;

  led_pwm_sequencer dut (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .pwm_o   (pwm_o),
    .frame_o (frame_o),
    .phase_o (phase_o)
  );

  int checks = 0;
  int errors = 0;
  int win_cnt [NUM_CH];

  task automatic check_val(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", tag, actual, expected, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_en, m_presc, m_pc, m_ticks;
  int m_sh_mode [NUM_CH];
  int m_sh_duty [NUM_CH];
  int m_lv_mode [NUM_CH];
  int m_lv_duty [NUM_CH];
  int m_pwm     [NUM_CH];
  int m_g       [NUM_CH];
  int m_cnt_d, m_frame_d;

  // PWM count and phase follow directly from the number of ticks since clear.
  function automatic int m_cnt();
    return m_ticks % 256;
  endfunction

  function automatic int m_phase();
    return (m_ticks / 256) % 256;
  endfunction

  function automatic int lvl(input int e);
`ifdef LED_PWM_GAMMA_EN
    return (e * e) / 256;
`else
    return e;
`endif
  endfunction

  function automatic int eff_of(input int mode, input int duty, input int ph);
    int tri_v;
    case (mode)
      1:       return duty;
      2:       return (ph >= 128) ? 0 : duty;
      3: begin
        tri_v = (ph < 128) ? ph : 255 - ph;
        return (duty * tri_v) / 128;
      end
      default: return 0;
    endcase
  endfunction

  function automatic int exp_frame();
`ifdef LED_PWM_GAMMA_EN
    return m_frame_d;
`else
    return ((m_pc == m_presc) && (m_cnt() == 255)) ? 1 : 0;
`endif
  endfunction

  task automatic model_reset();
    m_en = 0; m_presc = 46; m_pc = 0; m_ticks = 0; m_cnt_d = 0; m_frame_d = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      m_sh_mode[c] = 0; m_sh_duty[c] = 0; m_lv_mode[c] = 0; m_lv_duty[c] = 0;
      m_pwm[c] = 0; m_g[c] = 0;
    end
  endtask

  task automatic model_edge();
    int cnt, ph, tick, wrap, clr, a, d, e, ch;
    cnt  = m_cnt();
    ph   = m_phase();
    tick = (m_pc == m_presc) ? 1 : 0;
    wrap = (tick == 1 && cnt == 255) ? 1 : 0;
    a    = int'(wr_addr);
    d    = int'(wr_data);
    clr  = (wr_en && a == 0 && ((d >> 1) & 1) == 1) ? 1 : 0;
    for (int c = 0; c < NUM_CH; c++) begin
      e = eff_of(m_lv_mode[c], m_lv_duty[c], ph);
`ifdef LED_PWM_GAMMA_EN
      m_pwm[c] = (clr == 0 && m_en == 1 && m_cnt_d < m_g[c]) ? 1 : 0;
      m_g[c]   = lvl(e);
`else
      m_pwm[c] = (clr == 0 && m_en == 1 && cnt < e) ? 1 : 0;
`endif
      if (wrap == 1 || clr == 1) begin
        m_lv_mode[c] = m_sh_mode[c];
        m_lv_duty[c] = m_sh_duty[c];
      end
    end
    m_cnt_d   = cnt;
    m_frame_d = wrap;
    if (clr == 1) begin
      m_pc = 0; m_ticks = 0;
    end else begin
      m_ticks = m_ticks + tick;
      m_pc    = (m_pc >= m_presc) ? 0 : m_pc + 1;
    end
    if (wr_en) begin
      if (a == 0) m_en = d & 1;
      else if (a == 1) m_presc = d;
      else if (a < 2 + 2 * NUM_CH) begin
        ch = (a - 2) / 2;
        if (a % 2 == 1) m_sh_duty[ch] = d & 255;
        else            m_sh_mode[ch] = d & 3;
      end
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic step();
    logic [31:0] e_pwm;
    @(posedge clk);
    model_edge();
    #1;
    e_pwm = '0;
    for (int c = 0; c < NUM_CH; c++) e_pwm[c] = (m_pwm[c] != 0);
    check_val("pwm_o", {29'd0, pwm_o}, e_pwm);
    check_val("frame_o", {31'd0, frame_o}, exp_frame());
    check_val("phase_o", {24'd0, phase_o}, m_phase());
  endtask

  task automatic reg_write(input int addr, input int data);
    wr_en = 1'b1; wr_addr = addr[3:0]; wr_data = data[15:0];
    $display("write addr=%0d data=0x%04h", addr, data[15:0]);
    step();
    wr_en = 1'b0;
  endtask

  task automatic wait_frame(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (frame_o !== 1'b1 && n < 70000);
    if (frame_o !== 1'b1) check_val("frame_timeout", 0, 1);
  endtask

  task automatic count_window(input int n);
    for (int c = 0; c < NUM_CH; c++) win_cnt[c] = 0;
    for (int k = 0; k < n; k++) begin
      step();
      for (int c = 0; c < NUM_CH; c++) win_cnt[c] += int'(pwm_o[c]);
    end
  endtask

  // Window covering the frame whose phase is p.
  task automatic measure_phase(input int p);
    int n, target;
    target = (p + 255 + LAT_EXTRA) % 256;
    n = 0;
    do begin
      step();
      n++;
    end while (!(frame_o === 1'b1 && int'(phase_o) == target) && n < 70000);
    if (n >= 70000) check_val("phase_timeout", 0, 1);
    count_window(256);
  endtask

  initial begin
    int n, a, d;
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_val("reset_pwm", {29'd0, pwm_o}, 0);
    check_val("reset_frame", {31'd0, frame_o}, 0);
    check_val("reset_phase", {24'd0, phase_o}, 0);
    rst = 1'b0;
    step();

    // Static duties: 64, 0, full scale
    reg_write(1, 0);
    reg_write(0, 1);
    reg_write(2, 1); reg_write(3, 64);
    reg_write(4, 1); reg_write(5, 0);
    reg_write(6, 1); reg_write(7, 255);
    wait_frame(n);
    count_window(256);
    check_val("static64_count", win_cnt[0], lvl(64));
    check_val("duty0_count", win_cnt[1], 0);
    check_val("duty255_count", win_cnt[2], lvl(255));

    // PRESC=3 frame period and deferred DUTY update
    reg_write(1, 3);
    reg_write(0, 3);
    wait_frame(n);
    wait_frame(n);
    check_val("frame_period", n, 1024);
    reg_write(3, 200);
    repeat (300) step();
    check_val("duty_hold", {31'd0, pwm_o[0]}, 0);
    wait_frame(n);
    repeat (300) step();
    check_val("duty_update", {31'd0, pwm_o[0]}, 1);
    check_val("pre_clear_pwm2", {31'd0, pwm_o[2]}, 1);

    // Clear mid-frame
    reg_write(0, 3);
    check_val("clear_pwm", {29'd0, pwm_o}, 0);
    check_val("clear_phase", {24'd0, phase_o}, 0);
    wait_frame(n);
    check_val("clear_to_frame", n, 1023 + LAT_EXTRA);

    // Randomized register traffic against the model
    for (int k = 0; k < 2500; k++) begin
      if ($urandom_range(0, 7) == 0) begin
        a = $urandom_range(0, 15);
        d = $urandom_range(0, 65535);
        if (a == 1) d = d & 3;
        reg_write(a, d);
      end else begin
        step();
      end
    end

    // Breathe on ch0, blink on ch2, PRESC=0
    reg_write(1, 0);
    reg_write(2, 3); reg_write(3, 255);
    reg_write(4, 0);
    reg_write(6, 2); reg_write(7, 128);
    reg_write(0, 3);
    measure_phase(127);
    check_val("breathe_p127", win_cnt[0], lvl(253));
    check_val("blink_p127", win_cnt[2], lvl(128));
    measure_phase(128);
    check_val("breathe_p128", win_cnt[0], lvl(253));
    check_val("blink_p128", win_cnt[2], 0);
    measure_phase(255);
    check_val("breathe_p255", win_cnt[0], 0);
    check_val("blink_p255", win_cnt[2], 0);
    measure_phase(0);
    check_val("breathe_p0", win_cnt[0], 0);
    check_val("blink_p0", win_cnt[2], lvl(128));

    // Asynchronous reset mid-frame with a channel driving high
    reg_write(4, 1); reg_write(5, 255);
    wait_frame(n);
    repeat (12) step();
    check_val("pre_rst_pwm1", {31'd0, pwm_o[1]}, 1);
    #3;
    rst = 1'b1;
    #1;
    check_val("rst_pwm", {29'd0, pwm_o}, 0);
    check_val("rst_frame", {31'd0, frame_o}, 0);
    check_val("rst_phase", {24'd0, phase_o}, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (5) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
